mux_arb_m: RTL and testbench



---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_arb_m_if.sv | 27 ++
 rtl/mux_arb_m_rr_arbiter.sv | 34 +++
 rtl/mux_arb_m.sv | 67 ++++++
 tb/tb_mux_arb_m.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated N:1 mux.
package mux_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  typedef enum logic {ST_EMPTY, ST_FULL} out_st_e;

  function automatic int sel_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_m_if.sv
// Producer/consumer bundle for mux_arb_m; slave is the mux side.
interface mux_arb_m_if
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) ();
  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0][WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [WIDTH-1:0]               out_data;
  logic [SEL_W-1:0]               out_sel;
  logic                           out_valid;
  logic                           out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_arb_m_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter_m #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                any
);
  // cand[o] = (ptr + o) mod CHANNELS, the channel examined at scan offset o
  logic [CHANNELS-1:0][SEL_W-1:0] cand;

  for (genvar o = 0; o < CHANNELS; o++) begin : g_cand
    logic [SEL_W:0] sum;
    assign sum = {1'b0, ptr} + (SEL_W+1)'(o);
    assign cand[o] = (sum >= (SEL_W+1)'(CHANNELS)) ?
                     SEL_W'(sum - (SEL_W+1)'(CHANNELS)) : sum[SEL_W-1:0];
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int o = 0; o < CHANNELS; o++) begin
      if (!any && req[cand[o]]) begin
        any           = 1'b1;
        gnt_idx       = cand[o];
        gnt[cand[o]]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_arb_m.sv
// N-channel valid/ready mux with RR or fixed-priority arbitration and a
// single registered output slot that sustains one item per cycle.
module mux_arb_m
  import mux_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        CHANNELS = 4,
  parameter arb_mode_e MODE     = ARB_RR
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arb_m_if.slave   bus
);
  localparam int SEL_W = sel_width(CHANNELS);

  out_st_e             state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_nxt;
  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CHANNELS-1:0] gnt;
  logic [SEL_W-1:0]    gnt_idx;
  logic                any, load_en, take;

  rr_arbiter_m #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // rst_n gates the handshake so nothing is accepted while reset is held
  assign load_en      = (state_q == ST_EMPTY) || bus.out_ready;
  assign take         = load_en && any && rst_n;
  assign bus.in_ready = take ? gnt : '0;
  assign ptr_nxt      = (gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (take) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready) state_d = take ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else if (take) begin
      data_q <= bus.in_data[gnt_idx];
      sel_q  <= gnt_idx;
      if (MODE == ARB_RR) ptr_q <= ptr_nxt;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = (state_q == ST_FULL);
endmodule

// File: tb/tb_mux_arb_m.sv
// Directed bench: RR instance for most scenarios, fixed-priority instance alongside.
module tb_mux_arb_m;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_arb_m_if #(.WIDTH(8), .CHANNELS(4)) b1 ();
  mux_arb_m_if #(.WIDTH(8), .CHANNELS(4)) b2 ();

  mux_arb_m #(.WIDTH(8), .CHANNELS(4), .MODE(ARB_RR))    u_rr (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux_arb_m #(.WIDTH(8), .CHANNELS(4), .MODE(ARB_FIXED)) u_fx (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, "_vld"}, 32'(b1.out_valid), 32'(v));
    chk({tag, "_dat"}, 32'(b1.out_data), 32'(d));
    chk({tag, "_sel"}, 32'(b1.out_sel), 32'(s));
  endtask

  logic [1:0] exp_sel [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    b1.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b1.in_valid  = 4'b1111;
    b1.out_ready = 1'b1;
    b2.in_data   = '0;
    b2.in_valid  = 4'b1111;
    b2.out_ready = 1'b1;

    // reset held with every channel requesting
    @(negedge clk);
    chk("rst_rdy", 32'(b1.in_ready), 32'h0);
    chk("rst_rdy_fx", 32'(b2.in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);

    rst_n = 1'b1;
    b2.in_valid = 4'b0000;
    #1;
    chk("rel_rdy", 32'(b1.in_ready), 32'b0001);

    // round-robin streaming, one item per edge
    for (int k = 0; k < 6; k++) begin
      step();
      chk_out($sformatf("rr%0d", k), 1'b1, 8'hA0 + 8'(exp_sel[k]), exp_sel[k]);
    end

    b1.in_valid = 4'b0000;
    step();
    chk_out("drain", 1'b0, 8'hA1, 2'd1);

    // back-pressure: ptr=2, load 5C from ch2 then stall
    b1.in_data[2] = 8'h5C;
    b1.in_valid   = 4'b0100;
    step();
    chk_out("bp_load", 1'b1, 8'h5C, 2'd2);
    b1.in_valid   = 4'b1000;
    b1.in_data[3] = 8'h77;
    b1.out_ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_rdy%0d", k), 32'(b1.in_ready), 32'h0);
      step();
      chk_out($sformatf("bp_hold%0d", k), 1'b1, 8'h5C, 2'd2);
    end
    b1.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(b1.in_ready), 32'b1000);
    step();
    chk_out("bp_refill", 1'b1, 8'h77, 2'd3);

    // ch3 transfer wrapped ptr to 0; idle cycles must not move it
    b1.in_valid = 4'b0000;
    step();
    chk_out("wrap_drain", 1'b0, 8'h77, 2'd3);
    step();
    step();
    b1.in_data[0] = 8'h10;
    b1.in_data[2] = 8'h12;
    b1.in_valid   = 4'b0101;
    #1;
    chk("wrap_rdy", 32'(b1.in_ready), 32'b0001);
    step();
    chk_out("wrap_c0", 1'b1, 8'h10, 2'd0);
    b1.in_valid = 4'b0100;
    #1;
    chk("wrap_rdy2", 32'(b1.in_ready), 32'b0100);
    step();
    chk_out("wrap_c2", 1'b1, 8'h12, 2'd2);
    b1.in_valid = 4'b0000;
    step();
    chk_out("wrap_empty", 1'b0, 8'h12, 2'd2);

    // asynchronous reset while FULL
    b1.in_data[0] = 8'hFF;
    b1.in_valid   = 4'b0001;
    step();
    chk_out("mid_load", 1'b1, 8'hFF, 2'd0);
    b1.in_valid  = 4'b1111;
    b1.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 8'h00, 2'd0);
    chk("mid_rst_rdy", 32'(b1.in_ready), 32'h0);
    @(negedge clk);
    chk("mid_rst_hold", 32'(b1.out_valid), 32'h0);
    rst_n = 1'b1;
    b1.in_valid  = 4'b0000;
    b1.out_ready = 1'b1;

    // fixed priority: ch1 beats ch3 until it lets go
    b2.in_data[1] = 8'h31;
    b2.in_data[3] = 8'h33;
    b2.in_valid   = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fx_rdy%0d", k), 32'(b2.in_ready), 32'b0010);
      step();
      chk($sformatf("fx_sel%0d", k), 32'(b2.out_sel), 32'd1);
      chk($sformatf("fx_dat%0d", k), 32'(b2.out_data), 32'h31);
    end
    b2.in_valid = 4'b1000;
    #1;
    chk("fx_rdy3", 32'(b2.in_ready), 32'b1000);
    step();
    chk("fx_sel3", 32'(b2.out_sel), 32'd3);
    chk("fx_dat3", 32'(b2.out_data), 32'h33);
    b2.in_valid = 4'b0000;
    step();
    chk("fx_empty", 32'(b2.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
